// File: rtl/keccak_pkg.sv
// keccak_pkg: mode encodings, rate table and padding constants shared by the Keccak input loader
package keccak_pkg;
    typedef enum logic [1:0] {
        MODE_SHA3_256 = 2'b00,
        MODE_SHA3_512 = 2'b01,
        MODE_SHAKE128 = 2'b10,
        MODE_SHAKE256 = 2'b11
    } mode_e;
    typedef enum logic [2:0] {IDLE, LOAD, PAD, ZFILL, WAIT} state_e;
    localparam logic [7:0] SFX_SHA3 = 8'h06;
    localparam logic [7:0] SFX_SHAKE = 8'h1F;
    localparam logic [7:0] PAD_END = 8'h80;
    function automatic logic [5:0] rate_words(input logic [1:0] m);
        return (m == MODE_SHA3_512) ? 6'd18 : (m == MODE_SHAKE128) ? 6'd42 : 6'd34;
    endfunction
    function automatic logic [7:0] suffix(input logic [1:0] m);
        return m[1] ? SFX_SHAKE : SFX_SHA3;
    endfunction
    // keep bytes below n, put the suffix at byte n, zero the rest
    function automatic logic [31:0] pad_word(input logic [31:0] w, input logic [2:0] n, input logic [7:0] sfx);
        logic [31:0] r;
        for (int i = 0; i < 4; i++)
            r[8*i +: 8] = (i < int'(n)) ? w[8*i +: 8] : (i == int'(n)) ? sfx : 8'h00;
        return r;
    endfunction
endpackage

// File: rtl/sr_reg.sv
// sr_reg: set/clear flag register; set wins over clear, rst returns it to INIT
module sr_reg #(
    parameter logic INIT = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic set,
    input  logic clr,
    output logic q
);
    always_ff @(posedge clk)
        if (rst) q <= INIT;
        else if (set) q <= 1'b1;
        else if (clr) q <= 1'b0;
endmodule

// File: rtl/keccak_input_loader.sv
// keccak_input_loader: packs message beats into rate-sized Keccak blocks with SHA3/SHAKE padding
module keccak_input_loader
    import keccak_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] in_data,
    input  logic        in_valid,
    input  logic        in_last,
    input  logic [2:0]  in_nbytes,
    output logic        in_ready,
    input  logic [1:0]  cfg_mode,
    input  logic [31:0] cfg_out_bits,
    output logic        blk_we,
    output logic [5:0]  blk_addr,
    output logic [31:0] blk_data,
    output logic        block_ready,
    output logic        msg_end,
    input  logic        block_ready_clr,
    input  logic        msg_end_clr,
    output logic [31:0] d,
    output logic [1:0]  mode
);
    state_e state, state_nxt;
    logic [5:0] cnt, rate, base, wr_addr;
    logic [1:0] cur_mode;
    logic [31:0] data_q, wr_data, pw;
    logic [7:0] sfx;
    logic [2:0] nb_q;
    logic pend, fin, acc, fw, at_end, wr_en, wr_end, wr_final, end_q, final_q;
    assign cur_mode = (state == IDLE) ? cfg_mode : mode;
    assign rate = rate_words(cur_mode);
    assign sfx = suffix(cur_mode);
    assign base = (state == IDLE) ? 6'd0 : cnt;
    assign at_end = base == rate - 6'd1;
    assign acc = in_valid && in_ready;
    assign fw = in_nbytes == 3'd4;
    // a full last beat was already written, so PAD only emits the suffix-only word
    assign pw = (nb_q == 3'd4 ? {24'd0, sfx} : pad_word(data_q, nb_q, sfx)) | (at_end ? {PAD_END, 24'd0} : 32'd0);
    always_ff @(posedge clk)
        state <= rst ? IDLE : state_nxt;
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE, LOAD: if (acc) state_nxt = in_last ? ((fw && at_end) ? WAIT : PAD) : (at_end ? WAIT : LOAD);
            PAD, ZFILL: state_nxt = at_end ? WAIT : ZFILL;
            WAIT: if (fin ? (!block_ready && !msg_end && !end_q) : (block_ready && block_ready_clr))
                state_nxt = fin ? IDLE : pend ? PAD : LOAD;
            default: state_nxt = IDLE;
        endcase
    end
    always_comb begin
        in_ready = !rst && (state == IDLE || state == LOAD);
        wr_en = 1'b0;
        wr_addr = 6'd0;
        wr_data = 32'd0;
        wr_end = at_end;
        wr_final = 1'b0;
        case (state)
            IDLE, LOAD: if (acc && fw) begin
                wr_en = 1'b1;
                wr_addr = base;
                wr_data = in_data;
            end
            PAD: begin
                wr_en = 1'b1;
                wr_addr = cnt;
                wr_data = pw;
                wr_final = 1'b1;
            end
            ZFILL: begin
                wr_en = 1'b1;
                wr_addr = cnt;
                wr_data = at_end ? {PAD_END, 24'd0} : 32'd0;
                wr_final = 1'b1;
            end
            default: wr_en = 1'b0;
        endcase
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= 6'd0;
            mode <= 2'b00;
            d <= 32'd0;
            data_q <= 32'd0;
            nb_q <= 3'd0;
            pend <= 1'b0;
            fin <= 1'b0;
            blk_we <= 1'b0;
            blk_addr <= 6'd0;
            blk_data <= 32'd0;
            end_q <= 1'b0;
            final_q <= 1'b0;
        end else begin
            blk_we <= wr_en;
            blk_addr <= wr_addr;
            blk_data <= wr_data;
            end_q <= wr_en && wr_end;
            final_q <= wr_en && wr_final;
            if (acc) begin
                cnt <= base + 6'(fw);
                data_q <= in_data;
                nb_q <= in_nbytes;
                pend <= in_last && fw && at_end;
                fin <= 1'b0;
            end else if (state == PAD || state == ZFILL) begin
                cnt <= cnt + 6'd1;
                if (at_end) fin <= 1'b1;
            end else if (state == WAIT) cnt <= 6'd0;
            if (acc && state == IDLE) begin
                mode <= cfg_mode;
                d <= cfg_out_bits;
            end
        end
    end
    sr_reg #(.INIT(1'b0)) u_block_ready (
        .clk(clk), .rst(rst), .set(end_q), .clr(block_ready_clr), .q(block_ready)
    );
    sr_reg #(.INIT(1'b0)) u_msg_end (
        .clk(clk), .rst(rst), .set(end_q && final_q), .clr(msg_end_clr), .q(msg_end)
    );
endmodule

// File: tb/tb_keccak_input_loader.sv
// tb_keccak_input_loader: directed messages checked against a byte-level padding model of the expected block writes
module tb_keccak_input_loader;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic [31:0] in_data = 32'd0;
    logic in_valid = 1'b0, in_last = 1'b0;
    logic [2:0] in_nbytes = 3'd0;
    logic in_ready;
    logic [1:0] cfg_mode = 2'b00;
    logic [31:0] cfg_out_bits = 32'd0;
    logic blk_we, block_ready, msg_end;
    logic [5:0] blk_addr;
    logic [31:0] blk_data, d;
    logic block_ready_clr = 1'b0, msg_end_clr = 1'b0;
    logic [1:0] mode;
    typedef struct {
        logic [5:0] addr;
        logic [31:0] data;
        bit fin;
    } wr_t;
    wr_t exp_q[$];
    wr_t cur;
    logic [7:0] msg [0:511];
    logic [31:0] last_blk [0:63];
    int checks = 0, failures = 0;
    int clr_delay = 2, exp_rate = 34, wcount = 0, nblk = 0;
    logic [31:0] exp_d = 32'd0;
    logic [1:0] exp_mode = 2'b00;
    bit br_prev = 1'b0, last_fin = 1'b0;

    always #5 clk = ~clk;

    keccak_input_loader dut (
        .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_last(in_last),
        .in_nbytes(in_nbytes), .in_ready(in_ready), .cfg_mode(cfg_mode), .cfg_out_bits(cfg_out_bits),
        .blk_we(blk_we), .blk_addr(blk_addr), .blk_data(blk_data), .block_ready(block_ready),
        .msg_end(msg_end), .block_ready_clr(block_ready_clr), .msg_end_clr(msg_end_clr),
        .d(d), .mode(mode)
    );

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", name, got, exp);
        end
    endtask

    function automatic int rate_of(input logic [1:0] m);
        case (m)
            2'b01: return 18;
            2'b10: return 42;
            default: return 34;
        endcase
    endfunction

    // pad the byte stream (suffix, zeros, 0x80 on the last rate byte) and split into block words
    task automatic build_model(input logic [1:0] m, input int n);
        int rw = rate_of(m);
        int len = (n / (rw * 4) + 1) * rw * 4;
        logic [7:0] pb [$];
        for (int i = 0; i < len; i++)
            pb.push_back(i < n ? msg[i] : (i == n) ? (m[1] ? 8'h1F : 8'h06) : 8'h00);
        pb[len-1] = pb[len-1] | 8'h80;
        exp_q.delete();
        for (int j = 0; j < len / 4; j++) begin
            wr_t e;
            e.addr = 6'(j % rw);
            e.data = {pb[4*j+3], pb[4*j+2], pb[4*j+1], pb[4*j]};
            e.fin = (j == len / 4 - 1);
            exp_q.push_back(e);
        end
        exp_rate = rw;
    endtask

    task automatic send_beat(input logic [31:0] w, input bit last, input logic [2:0] nb);
        int t = 0;
        in_data = w;
        in_last = last;
        in_nbytes = nb;
        in_valid = 1'b1;
        while (!in_ready && t < 2000) begin
            @(posedge clk);
            #1;
            t++;
        end
        if (!in_ready) chk("beat_accept_timeout", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_last = 1'b0;
    endtask

    task automatic send_msg(input logic [1:0] m, input logic [31:0] ob, input int n, input int dly);
        int nw = n / 4, rem = n % 4, nbeats, t;
        nbeats = (rem != 0) ? nw + 1 : (nw != 0 ? nw : 1);
        build_model(m, n);
        clr_delay = dly;
        nblk = 0;
        exp_d = ob;
        exp_mode = m;
        cfg_mode = m;
        cfg_out_bits = ob;
        for (int k = 0; k < nbeats; k++) begin
            logic [31:0] w = 32'hEEEEEEEE;
            int c = (k < nw) ? 4 : rem;
            for (int i = 0; i < c; i++) w[8*i +: 8] = msg[4*k+i];
            send_beat(w, k == nbeats - 1, 3'(c));
            cfg_mode = ~m;
            cfg_out_bits = ~ob;
        end
        t = 0;
        while ((exp_q.size() != 0 || block_ready || msg_end || !in_ready) && t < 3000) begin
            @(posedge clk);
            #1;
            t++;
        end
        chk("writes_outstanding", exp_q.size(), 32'd0);
        chk("idle_after_msg", 32'(in_ready), 32'd1);
    endtask

    task automatic chk_reset_vals();
        chk("rst_blk_we", 32'(blk_we), 32'd0);
        chk("rst_blk_addr", 32'(blk_addr), 32'd0);
        chk("rst_blk_data", blk_data, 32'd0);
        chk("rst_block_ready", 32'(block_ready), 32'd0);
        chk("rst_msg_end", 32'(msg_end), 32'd0);
        chk("rst_d", d, 32'd0);
        chk("rst_mode", 32'(mode), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd0);
    endtask

    // core side: acknowledge each block after clr_delay cycles
    initial begin
        forever begin
            @(posedge clk);
            #1;
            block_ready_clr = 1'b0;
            msg_end_clr = 1'b0;
            if (block_ready && !rst) begin
                repeat (clr_delay) begin
                    @(posedge clk);
                    #1;
                end
                block_ready_clr = 1'b1;
                msg_end_clr = msg_end;
            end
        end
    end

    always @(negedge clk) begin
        if (rst) begin
            wcount = 0;
            br_prev = 1'b0;
        end else begin
            if (blk_we) begin
                if (exp_q.size() == 0) chk("unexpected_write", 32'(blk_we), 32'd0);
                else begin
                    cur = exp_q.pop_front();
                    chk("blk_addr", 32'(blk_addr), 32'(cur.addr));
                    chk("blk_data", blk_data, cur.data);
                    last_blk[blk_addr] = blk_data;
                    last_fin = cur.fin;
                    wcount++;
                end
                chk("d_stable", d, exp_d);
                chk("mode_stable", 32'(mode), 32'(exp_mode));
            end
            if (block_ready && !br_prev) begin
                chk("words_per_block", wcount, exp_rate);
                chk("msg_end_with_block", 32'(msg_end), 32'(last_fin));
                wcount = 0;
                nblk++;
            end
            if (block_ready) begin
                chk("wait_in_ready", 32'(in_ready), 32'd0);
                chk("wait_no_write", 32'(blk_we), 32'd0);
                chk("wait_d", d, exp_d);
                chk("wait_mode", 32'(mode), 32'(exp_mode));
            end
            br_prev = block_ready;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 512; i++) msg[i] = 8'(i * 7 + 3);
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk_reset_vals();
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("ready_after_rst", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1;
        build_model(2'b00, 0);
        chk("model_empty_len", exp_q.size(), 32'd34);
        chk("model_empty_w0", exp_q[0].data, 32'h00000006);
        chk("model_empty_w33", exp_q[33].data, 32'h80000000);
        send_msg(2'b00, 32'd256, 0, 2);
        chk("sha3_256_empty_w0", last_blk[0], 32'h00000006);
        chk("sha3_256_empty_w33", last_blk[33], 32'h80000000);
        chk("sha3_256_empty_blocks", nblk, 32'd1);
        msg[0] = 8'h61;
        msg[1] = 8'h62;
        msg[2] = 8'h63;
        send_msg(2'b10, 32'd256, 3, 1);
        chk("shake128_abc_w0", last_blk[0], 32'h1F636261);
        chk("shake128_abc_w41", last_blk[41], 32'h80000000);
        chk("shake128_abc_blocks", nblk, 32'd1);
        for (int i = 0; i < 512; i++) msg[i] = 8'(i * 7 + 3);
        send_msg(2'b01, 32'd512, 72, 3);
        chk("sha3_512_72_w0", last_blk[0], 32'h00000006);
        chk("sha3_512_72_w17", last_blk[17], 32'h80000000);
        chk("sha3_512_72_blocks", nblk, 32'd2);
        build_model(2'b11, 135);
        chk("model_135_w33_top", 32'(exp_q[33].data[31:24]), 32'h9F);
        send_msg(2'b11, 32'd4096, 135, 0);
        chk("shake256_135_w33_top", 32'(last_blk[33][31:24]), 32'h9F);
        chk("shake256_135_blocks", nblk, 32'd1);
        send_msg(2'b10, 32'd1344, 400, 30);
        chk("shake128_400_blocks", nblk, 32'd3);
        send_msg(2'b00, 32'd256, 133, 1);
        chk("sha3_256_133_w33", last_blk[33], {8'h80, 8'h00, 8'h06, msg[132]});
        send_msg(2'b00, 32'd256, 4, 0);
        chk("sha3_256_4_w1", last_blk[1], 32'h00000006);
        build_model(2'b10, 100);
        exp_d = 32'd128;
        exp_mode = 2'b10;
        cfg_mode = 2'b10;
        cfg_out_bits = 32'd128;
        for (int k = 0; k < 10; k++)
            send_beat({msg[4*k+3], msg[4*k+2], msg[4*k+1], msg[4*k]}, 1'b0, 3'd4);
        rst = 1'b1;
        @(negedge clk);
        chk("rst_mid_in_ready", 32'(in_ready), 32'd0);
        @(posedge clk);
        #1;
        exp_q.delete();
        @(negedge clk);
        chk_reset_vals();
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("ready_after_mid_rst", 32'(in_ready), 32'd1);
        repeat (5) @(posedge clk);
        #1;
        send_msg(2'b00, 32'd256, 5, 2);
        chk("post_rst_w0", last_blk[0], 32'h18110A03);
        chk("post_rst_w1", last_blk[1], {16'h0000, 8'h06, msg[4]});
        chk("post_rst_w33", last_blk[33], 32'h80000000);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
